// File: rtl/wb_buffer_pkg.sv
// wb_buffer_pkg: shared entry type, widths and pointer helper for the dirty write-back buffer
package wb_buffer_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DEPTH = 4;
  localparam int PTR_W = $clog2(WB_DEPTH);
  typedef struct packed {
    logic valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return p + 1'b1;
  endfunction
endpackage

// File: rtl/wb_buffer_cam.sv
// wb_buffer_cam: match one address against all valid, unmasked entries
module wb_buffer_cam
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  wb_entry_t [DEPTH-1:0]     ents,
  input  logic      [DEPTH-1:0]     mask,
  input  logic      [WB_ADDR_W-1:0] addr,
  output logic      [DEPTH-1:0]     match,
  output logic      [WB_DATA_W-1:0] data
);
  always_comb begin
    match = '0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = mask[i] && ents[i].valid && ents[i].addr == addr;
      data = data | (match[i] ? ents[i].data : '0);
    end
  end
endmodule

// File: rtl/dirty_wb_buffer.sv
// dirty_wb_buffer: posted FIFO of dirty evictions with coalescing, drained to data memory by ready/valid
module dirty_wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ADDR_WIDTH = WB_ADDR_W,
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_en,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic [DATA_WIDTH-1:0]   push_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    mem_ready,
  input  logic [ADDR_WIDTH-1:0]   lookup_addr,
  output logic                    lookup_hit,
  output logic [DATA_WIDTH-1:0]   lookup_data,
  output logic                    overflow_err
);
  wb_entry_t [DEPTH-1:0] ents;
  logic [PTR_W-1:0] head, tail;
  logic [DEPTH-1:0] valid, head_oh, co_match, lk_match;
  logic [DATA_WIDTH-1:0] co_unused;
  logic pop, co, app, drop;
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) valid[i] = ents[i].valid;
  end
  assign empty = count == '0;
  assign full = count == ($clog2(DEPTH)+1)'(DEPTH);
  assign mem_wr_en = !empty;
  assign mem_addr = ents[head].addr;
  assign mem_data = ents[head].data;
  assign pop = mem_wr_en && mem_ready;
  assign head_oh = DEPTH'(1) << head;
  // The head leaving this cycle must not absorb a new write, or memory would miss the newer value.
  wb_buffer_cam #(.DEPTH(DEPTH)) u_co_cam (
    .ents(ents),
    .mask(pop ? ~head_oh : '1),
    .addr(push_addr),
    .match(co_match),
    .data(co_unused)
  );
  wb_buffer_cam #(.DEPTH(DEPTH)) u_lk_cam (
    .ents(ents),
    .mask('1),
    .addr(lookup_addr),
    .match(lk_match),
    .data(lookup_data)
  );
  assign lookup_hit = |lk_match;
  assign co = push_en && |co_match;
  assign app = push_en && !co && (!full || pop);
  assign drop = push_en && !co && !app;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ents <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (pop) begin
        ents[head].valid <= 1'b0;
        head <= next_ptr(head);
      end
      for (int i = 0; i < DEPTH; i++) if (co && co_match[i]) ents[i].data <= push_data;
      if (app) begin
        ents[tail] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        tail <= next_ptr(tail);
      end
      count <= count + ($clog2(DEPTH)+1)'(app) - ($clog2(DEPTH)+1)'(pop);
      overflow_err <= overflow_err | drop;
    end
  end
endmodule

// File: tb/tb_dirty_wb_buffer.sv
// tb_dirty_wb_buffer: scoreboard bench; a reference queue predicts every memory write and lookup
module tb_dirty_wb_buffer;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, push_en = 0, mem_ready = 0;
  logic [31:0] push_addr = 0, push_data = 0, lookup_addr = 0;
  logic full, empty, mem_wr_en, lookup_hit, overflow_err;
  logic [2:0] count;
  logic [31:0] mem_addr, mem_data, lookup_data;
  typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;
  ent_t q[$];
  bit m_ovf = 0;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  dirty_wb_buffer dut (
    .clk(clk), .rst(rst), .push_en(push_en), .push_addr(push_addr), .push_data(push_data),
    .full(full), .empty(empty), .count(count), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .overflow_err(overflow_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cycle(input bit pe, input logic [31:0] pa, input logic [31:0] pd, input bit rdy);
    bit pop;
    int ci;
    push_en = pe; push_addr = pa; push_data = pd; mem_ready = rdy;
    @(negedge clk);
    chk("mem_wr_en", mem_wr_en, 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("mem_addr", mem_addr, q[0].addr);
      chk("mem_data", mem_data, q[0].data);
    end
    pop = q.size() != 0 && rdy;
    ci = -1;
    if (pe) for (int i = pop ? 1 : 0; i < q.size(); i++) if (q[i].addr == pa) ci = i;
    if (ci >= 0) q[ci].data = pd;
    if (pop) void'(q.pop_front());
    if (pe && ci < 0) begin
      if (q.size() < DEPTH) q.push_back('{pa, pd});
      else m_ovf = 1;
    end
    @(posedge clk);
    #1;
    push_en = 0; mem_ready = 0;
    chk("count", count, 64'(q.size()));
    chk("empty", empty, 64'(q.size() == 0));
    chk("full", full, 64'(q.size() == DEPTH));
    chk("overflow_err", overflow_err, 64'(m_ovf));
  endtask
  task automatic look(input logic [31:0] a);
    bit h;
    logic [31:0] d;
    h = 0; d = 0;
    foreach (q[i]) if (q[i].addr == a) begin h = 1; d = q[i].data; end
    lookup_addr = a;
    #1;
    chk("lookup_hit", lookup_hit, 64'(h));
    chk("lookup_data", lookup_data, d);
  endtask
  task automatic drain;
    for (int i = 0; i < 2 * DEPTH && q.size() != 0; i++) cycle(0, 0, 0, 1);
    chk("drained_empty", empty, 1);
  endtask
  task automatic do_reset;
    #2 rst = 0;
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", overflow_err, 0);
    q.delete();
    m_ovf = 0;
    @(posedge clk);
    #1 rst = 1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #1 rst = 0;
    #2;
    chk("reset_empty", empty, 1);
    chk("reset_full", full, 0);
    chk("reset_count", count, 0);
    chk("reset_wr_en", mem_wr_en, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_data", mem_data, 0);
    chk("reset_ovf", overflow_err, 0);
    lookup_addr = 32'h100;
    #1;
    chk("reset_hit", lookup_hit, 0);
    chk("reset_lookup_data", lookup_data, 0);
    @(posedge clk);
    #1 rst = 1;
    cycle(1, 32'h100, 32'hAAAA_0001, 0);
    look(32'h100);
    look(32'h104);
    drain;
    for (int i = 1; i <= 4; i++) cycle(1, 32'(i * 16), 32'hD000 + 32'(i), 0);
    cycle(1, 32'h50, 32'hD005, 0);
    cycle(0, 0, 0, 0);
    drain;
    chk("ovf_held", overflow_err, 1);
    do_reset;
    for (int i = 1; i <= 4; i++) cycle(1, 32'(i * 16), 32'hE000 + 32'(i), 0);
    cycle(1, 32'h50, 32'hE005, 1);
    drain;
    cycle(1, 32'h10, 32'h1111, 0);
    cycle(1, 32'h20, 32'h2222, 0);
    cycle(1, 32'h20, 32'hBEEF, 0);
    look(32'h20);
    drain;
    cycle(1, 32'h10, 32'h1, 0);
    cycle(1, 32'h10, 32'h2, 1);
    drain;
    repeat (400) begin
      cycle(1'($urandom_range(0, 1)), 32'($urandom_range(1, 6)) << 4, $urandom, 1'($urandom_range(0, 2) == 0));
      look(32'($urandom_range(1, 6)) << 4);
    end
    drain;
    for (int i = 1; i <= 3; i++) cycle(1, 32'(i * 256), 32'hC000 + 32'(i), 0);
    do_reset;
    cycle(0, 0, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dirty_wb_buffer.md
Name: dirty_wb_buffer

Overview:
- Posted write-back buffer between the cache eviction port (dirty address, dirty data, dirty enable) and data_memory.
- Absorbs dirty-line evictions in a small FIFO, then drains them to memory with a ready/valid handshake, so an eviction never stalls the memory stage while memory is busy.
- Provides a combinational address lookup so the cache's refill path returns buffered data instead of stale memory data.

Parameters:
- DATA_WIDTH, 32, width of an evicted word.
- ADDR_WIDTH, 32, byte address width.
- DEPTH, 4, number of buffer entries; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- push_en  in  1  eviction valid (cache dirty enable).
- push_addr  in  ADDR_WIDTH  eviction address.
- push_data  in  DATA_WIDTH  eviction data.
- full  out  1  no free entry; upstream must stall the eviction.
- empty  out  1  no valid entry.
- count  out  $clog2(DEPTH)+1  number of valid entries.
- mem_wr_en  out  1  head entry valid toward data_memory.
- mem_addr  out  ADDR_WIDTH  head entry address.
- mem_data  out  DATA_WIDTH  head entry data.
- mem_ready  in  1  data_memory accepts the head this cycle.
- lookup_addr  in  ADDR_WIDTH  refill address from the cache.
- lookup_hit  out  1  lookup_addr matches a valid entry.
- lookup_data  out  DATA_WIDTH  data of the matching entry.
- overflow_err  out  1  sticky: a push was dropped.

Behaviour:
- Reset (rst low, async):
  - head/tail pointers = 0, count = 0, all valid bits = 0, all entry addr/data = 0, overflow_err = 0.
  - Therefore empty = 1, full = 0, mem_wr_en = 0, mem_addr = 0, mem_data = 0, lookup_hit = 0, lookup_data = 0.
- Outputs:
  - empty = (count == 0); full = (count == DEPTH).
  - mem_wr_en = !empty; mem_addr/mem_data are the head entry fields. These are registered-storage reads; there is no combinational path from the push inputs.
- Pop: happens when mem_wr_en && mem_ready at the clock edge. The head valid bit clears, head pointer increments modulo DEPTH, and count decrements.
- Push (push_en high), evaluated at the clock edge against pre-edge state:
  - a) Coalesce: push_addr equals the address of a valid entry that is not being popped this cycle. That entry's data is overwritten in place; count, pointers and FIFO order are unchanged.
  - b) Append: otherwise, if count < DEPTH, or count == DEPTH with a pop this same cycle. The entry is written at tail, valid set, tail increments modulo DEPTH.
  - c) Drop: otherwise (full, no pop, no coalesce). The push is discarded, state is unchanged, and overflow_err sets and holds until reset.
- If the matching entry is the head being popped, case (a) does not apply and the push appends. Memory receives the old value, then the new one; memory order is preserved.
- Addresses are unique across valid entries, so a coalesce never matches more than one entry.
- Count update:
  - append without pop: +1
  - pop without append: −1
  - append with pop: unchanged
  - coalesce with pop: −1
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty come only from count.
- Lookup is combinational over the valid entries:
  - lookup_hit = any valid entry's addr == lookup_addr; lookup_data = that entry's data, else 0.
  - The lookup reflects pre-edge state only; a same-cycle push is not forwarded.
- Latency: an appended entry is visible on mem_* in the cycle after the push edge, if it is the head. The minimum push-to-memory time is 1 cycle.
- Reset mid-drain: all entries are discarded immediately and mem_wr_en falls asynchronously. Memory writes already completed are not rolled back.

Decomposition:
- Package wb_buffer_pkg:
  - typedef wb_entry_t {valid, addr, data}.
  - localparam PTR_W = $clog2(DEPTH).
  - function next_ptr() for modulo increment.
- Sub-module wb_buffer_cam: a combinational match of one address against all entries. It returns a one-hot match vector and the selected data. It is instantiated twice: once for push coalescing (with the popping head masked) and once for lookup.

Test Plan:
- Reset release, then push 0x100/0xAAAA_0001 with mem_ready = 0: next cycle count = 1, mem_wr_en = 1, mem_addr = 0x100, mem_data = 0xAAAA_0001; lookup_addr 0x100 gives hit = 1, data = 0xAAAA_0001.
- mem_ready = 0, push 4 distinct addresses 0x10, 0x20, 0x30, 0x40: full = 1, count = 4. A 5th push to 0x50 gives count 4 and overflow_err = 1 (held). Then raise mem_ready for 4 cycles: mem_addr sequence is 0x10, 0x20, 0x30, 0x40, then empty = 1.
- Full buffer, same-cycle push 0x50 and mem_ready = 1: count stays 4, no overflow_err. Drain order is 0x20, 0x30, 0x40, 0x50, exercising tail wrap.
- Entries 0x10, 0x20 present, mem_ready = 0, push 0x20/0xBEEF: count stays 2, lookup 0x20 returns 0xBEEF. Drain writes 0x10, then 0x20 = 0xBEEF.
- Head 0x10 = 1, push 0x10 = 2 with mem_ready = 1 same cycle: memory gets 0x10 = 1, then next entry 0x10 = 2; count goes 1 → 1.
- Three entries buffered, assert rst low mid-cycle: empty = 1, mem_wr_en = 0, count = 0 immediately, without waiting for a clock edge.
